sdram_cmd_responder: RTL and testbench

//  Single-clock responder for the SDRAM command/response FIFO protocol. It pops 41-bit

---
 rtl/sdram_cmd_responder_if.sv | 19 +
 rtl/sdram_cmd_responder.sv | 136 +++++++++++++
 tb/tb_sdram_cmd_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_responder_if.sv
// Command/response FIFO handshake between a test master and the SDRAM stand-in responder.
interface sdram_cmd_responder_if;
    logic [40:0] cmd_q_i;
    logic        cmd_empty_i;
    logic        cmd_deq_o;
    logic [15:0] rsp_d_o;
    logic        rsp_enq_o;
    logic        rsp_full_i;

    modport slave (
        input  cmd_q_i, cmd_empty_i, rsp_full_i,
        output cmd_deq_o, rsp_d_o, rsp_enq_o
    );

    modport master (
        output cmd_q_i, cmd_empty_i, rsp_full_i,
        input  cmd_deq_o, rsp_d_o, rsp_enq_o
    );
endinterface

// File: rtl/sdram_cmd_responder.sv
// BRAM-backed SDRAM command responder: pops {we, addr, wdata}, waits LATENCY cycles,
// executes against on-chip memory and pushes read data into the response FIFO.
//
// state    | meaning
// S_IDLE   | waiting for a command; pops the FIFO head when one is present
// S_WAIT   | emulated access time, wait counter counting down to 1
// S_ACCESS | BRAM write, or BRAM read into the response register
// S_RESP   | read word presented; enqueued as soon as the response FIFO has room
module sdram_cmd_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      reset_i,
    sdram_cmd_responder_if.slave      bus,
    output logic                      busy_o,
    output logic                      oob_o,
    output logic [15:0]               wr_count_o,
    output logic [15:0]               rd_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] LAT = 8'(LATENCY);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [15:0]         cmd_wdata_q, cmd_wdata_d;
    logic                oob_q, oob_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         rsp_d_q;
    logic                deq, enq, mem_we, mem_re;

    logic [15:0]         mem [0:(1<<ADDR_W)-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        oob_d       = oob_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        deq         = 1'b0;
        enq         = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.cmd_empty_i && !reset_i) begin
                    deq         = 1'b1;
                    cmd_we_d    = bus.cmd_q_i[40];
                    cmd_addr_d  = bus.cmd_q_i[16 +: ADDR_W];
                    cmd_wdata_d = bus.cmd_q_i[15:0];
                    cnt_d       = LAT;
                    if (bus.cmd_q_i[39:16+ADDR_W] != '0)
                        oob_d = 1'b1;
                    state_d     = (LAT == 8'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cmd_we_q) begin
                    mem_we     = !reset_i;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = S_IDLE;
                end else begin
                    mem_re     = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                // A reset in RESP drops the pending response rather than pushing it.
                if (!bus.rsp_full_i && !reset_i) begin
                    enq        = 1'b1;
                    rd_count_d = rd_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            oob_q       <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            oob_q       <= oob_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

    // Memory and its output register kept in plain BRAM form; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[cmd_addr_q] <= cmd_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset_i)
            rsp_d_q <= '0;
        else if (mem_re)
            rsp_d_q <= mem[cmd_addr_q];
    end

    assign bus.cmd_deq_o = deq;
    assign bus.rsp_enq_o = enq;
    assign bus.rsp_d_o   = rsp_d_q;
    assign busy_o        = (state_q != S_IDLE);
    assign oob_o         = oob_q;
    assign wr_count_o    = wr_count_q;
    assign rd_count_o    = rd_count_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: FIFO feeder, memory model and response scoreboard.
module tb_sdram_cmd_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst0;
    logic        busy, oob, busy0, oob0;
    logic [15:0] wrc, rdc, wrc0, rdc0;

    sdram_cmd_responder_if bus ();
    sdram_cmd_responder_if bus0 ();

    sdram_cmd_responder #(.ADDR_W(14), .LATENCY(4)) u_dut (
        .clk(clk), .reset_i(rst), .bus(bus),
        .busy_o(busy), .oob_o(oob), .wr_count_o(wrc), .rd_count_o(rdc)
    );

    sdram_cmd_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_i(rst0), .bus(bus0),
        .busy_o(busy0), .oob_o(oob0), .wr_count_o(wrc0), .rd_count_o(rdc0)
    );

    logic [40:0] cq[$];
    logic [40:0] cq0[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_q0[$];
    logic [15:0] mm[int];
    logic [15:0] mm0[int];

    int vec_cnt  = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Show-ahead command FIFOs: pop on deq at the edge, present the new head at the falling edge.
    always @(posedge clk) begin
        if (bus.cmd_deq_o === 1'b1 && cq.size() != 0) void'(cq.pop_front());
        if (bus0.cmd_deq_o === 1'b1 && cq0.size() != 0) void'(cq0.pop_front());
    end

    always @(negedge clk) begin
        bus.cmd_empty_i  = (cq.size() == 0);
        bus.cmd_q_i      = (cq.size() != 0) ? cq[0] : '0;
        bus0.cmd_empty_i = (cq0.size() == 0);
        bus0.cmd_q_i     = (cq0.size() != 0) ? cq0[0] : '0;
    end

    always @(negedge clk) begin
        if (bus.rsp_enq_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                assert (exp_q.size() != 0) else begin
                    fail_cnt++;
                    $error("FAIL rsp_extra observed=%0h expected=none", bus.rsp_d_o);
                end
            end else
                chk("rsp_data", 32'(bus.rsp_d_o), 32'(exp_q.pop_front()));
        end
        if (bus0.rsp_enq_o === 1'b1) begin
            if (exp_q0.size() == 0) begin
                vec_cnt++;
                assert (exp_q0.size() != 0) else begin
                    fail_cnt++;
                    $error("FAIL rsp0_extra observed=%0h expected=none", bus0.rsp_d_o);
                end
            end else
                chk("rsp0_data", 32'(bus0.rsp_d_o), 32'(exp_q0.pop_front()));
        end
    end

    task automatic push_cmd(input bit sel0, input logic we, input logic [23:0] addr,
                            input logic [15:0] data, input bit expect_rsp);
        int idx;
        if (!sel0) begin
            idx = int'(addr) & 'h3FFF;
            cq.push_back({we, addr, data});
            if (we) mm[idx] = data;
            else if (expect_rsp) exp_q.push_back(mm[idx]);
        end else begin
            idx = int'(addr) & 'h3FF;
            cq0.push_back({we, addr, data});
            if (we) mm0[idx] = data;
            else if (expect_rsp) exp_q0.push_back(mm0[idx]);
        end
    endtask

    task automatic wait_idle(input bit sel0, input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!sel0 && cq.size() == 0 && bus.cmd_empty_i && !busy) break;
            if (sel0 && cq0.size() == 0 && bus0.cmd_empty_i && !busy0) break;
            tick();
        end
        chk({tag, "_idle_in_time"}, 32'(i < 400), 32'd1);
    endtask

    task automatic wait_deq(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            if (bus.cmd_deq_o === 1'b1) break;
            tick();
        end
        chk({tag, "_deq_in_time"}, 32'(i < 50), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rst0 = 1'b1;
        bus.rsp_full_i = 1'b0;
        bus0.rsp_full_i = 1'b0;
        repeat (3) tick();

        chk("rst_busy",    32'(busy),          32'd0);
        chk("rst_oob",     32'(oob),           32'd0);
        chk("rst_wrc",     32'(wrc),           32'd0);
        chk("rst_rdc",     32'(rdc),           32'd0);
        chk("rst_enq",     32'(bus.rsp_enq_o), 32'd0);
        chk("rst_rsp_d",   32'(bus.rsp_d_o),   32'd0);
        chk("rst_deq",     32'(bus.cmd_deq_o), 32'd0);
        chk("rst0_busy",   32'(busy0),         32'd0);
        rst = 1'b0;
        rst0 = 1'b0;
        tick();

        // Write, write, read-after-write
        push_cmd(0, 1'b1, 24'h001000, 16'h1000, 0);
        push_cmd(0, 1'b1, 24'h002000, 16'h2000, 0);
        push_cmd(0, 1'b0, 24'h001000, 16'h0000, 1);
        wait_idle(0, "t1");
        chk("t1_wrc",    32'(wrc),            32'd2);
        chk("t1_rdc",    32'(rdc),            32'd1);
        chk("t1_oob",    32'(oob),            32'd0);
        chk("t1_sb",     32'(exp_q.size()),   32'd0);

        // Read latency: enq exactly at cycle LATENCY+2, busy cycles 1..LATENCY+2
        push_cmd(0, 1'b0, 24'h002000, 16'h0000, 1);
        wait_deq("t2");
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("t2_busy_c%0d", k), 32'(busy),          32'(k <= 6));
            chk($sformatf("t2_enq_c%0d", k),  32'(bus.rsp_enq_o), 32'(k == 6));
        end

        // Backpressure: hold in RESP with data stable and no new pops
        bus.rsp_full_i = 1'b1;
        push_cmd(0, 1'b0, 24'h001000, 16'h0000, 1);
        wait_deq("t3");
        repeat (6) tick();
        push_cmd(0, 1'b1, 24'h000055, 16'h0055, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_noenq_%0d", k), 32'(bus.rsp_enq_o), 32'd0);
            chk($sformatf("t3_data_%0d", k),  32'(bus.rsp_d_o),   32'h1000);
            chk($sformatf("t3_nodeq_%0d", k), 32'(bus.cmd_deq_o), 32'd0);
            chk($sformatf("t3_busy_%0d", k),  32'(busy),          32'd1);
            tick();
        end
        @(posedge clk);
        #1;
        bus.rsp_full_i = 1'b0;
        tick();
        chk("t3_enq_release", 32'(bus.rsp_enq_o), 32'd1);
        tick();
        chk("t3_enq_single",  32'(bus.rsp_enq_o), 32'd0);
        chk("t3_rdc",         32'(rdc),           32'd3);
        wait_idle(0, "t3");
        chk("t3_wrc",         32'(wrc),           32'd3);
        chk("t3_rdc_final",   32'(rdc),           32'd3);

        // Reset during WAIT of a read: response dropped, next command still runs
        push_cmd(0, 1'b0, 24'h001000, 16'h0000, 0);
        push_cmd(0, 1'b0, 24'h002000, 16'h0000, 1);
        wait_deq("t6");
        tick();
        tick();
        chk("t6_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_busy",   32'(busy),          32'd0);
        chk("t6_enq",    32'(bus.rsp_enq_o), 32'd0);
        chk("t6_rsp_d",  32'(bus.rsp_d_o),   32'd0);
        chk("t6_deq",    32'(bus.cmd_deq_o), 32'd0);
        chk("t6_wrc",    32'(wrc),           32'd0);
        chk("t6_rdc",    32'(rdc),           32'd0);
        chk("t6_oob",    32'(oob),           32'd0);
        chk("t6_held",   32'(cq.size()),     32'd1);
        rst = 1'b0;
        tick();
        wait_idle(0, "t6");
        chk("t6_rdc_after", 32'(rdc),          32'd1);
        chk("t6_sb",        32'(exp_q.size()), 32'd0);

        // LATENCY=0 back-to-back writes then reads
        for (int i = 0; i < 8; i++)
            push_cmd(1, 1'b1, 24'(i), 16'(i) ^ 16'hA5A5, 0);
        for (int i = 0; i < 8; i++)
            push_cmd(1, 1'b0, 24'(i), 16'h0000, 1);
        wait_idle(1, "t4");
        chk("t4_wrc", 32'(wrc0),          32'd8);
        chk("t4_rdc", 32'(rdc0),          32'd8);
        chk("t4_sb",  32'(exp_q0.size()), 32'd0);
        chk("t4_oob", 32'(oob0),          32'd0);

        // Out-of-range write aliases onto index 0; oob is sticky
        push_cmd(1, 1'b1, 24'h000400, 16'hBEEF, 0);
        push_cmd(1, 1'b0, 24'h000000, 16'h0000, 1);
        wait_idle(1, "t5a");
        chk("t5_oob_set",    32'(oob0), 32'd1);
        push_cmd(1, 1'b0, 24'h000005, 16'h0000, 1);
        wait_idle(1, "t5b");
        chk("t5_oob_sticky", 32'(oob0),          32'd1);
        chk("t5_wrc",        32'(wrc0),          32'd9);
        chk("t5_rdc",        32'(rdc0),          32'd10);
        chk("t5_sb",         32'(exp_q0.size()), 32'd0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
